pseudo_acc_corrector: RTL and testbench
=======================================

PSEUDO_ACC_CORRECTOR -- requirements
Module: pseudo_acc_corrector

Interface
REQ-001 Parameters (name, default, meaning): TIMESTEPS 8 lanes per spike fibre; WEIGHT_WIDTH 8 weight bits; ACC_WIDTH 12 accumulator/result bits; ADDR_WIDTH 8 fibre-A address bits.
REQ-002 Ports (name direction width meaning): clk in 1 clock; rst in 1 reset, asynchronous, active-high.
REQ-003 fast_valid in 1 / fast_weight in WEIGHT_WIDTH / fast_ready out 1: matched-weight stream.
REQ-004 slow_valid in 1 / slow_weight in WEIGHT_WIDTH / slow_offset in ADDR_WIDTH / slow_ready out 1: correction-request stream.
REQ-005 fa_addr out ADDR_WIDTH / fa_read_en out 1 / fa_data in TIMESTEPS / fa_valid in 1: fibre-A memory read port.
REQ-006 row_end in 1 (single-cycle pulse, no further inputs for current row); result_data out TIMESTEPS*ACC_WIDTH (lane t at bits [t*ACC_WIDTH +: ACC_WIDTH]); result_valid out 1; result_ready in 1; busy out 1.

Function
REQ-007 Beat transfers when valid && ready, same cycle; fast beat adds fast_weight (zero-extended) to pseudo accumulator.
REQ-008 fast_ready = !end_pending && state != OUTPUT; slow_ready = state == IDLE && !end_pending.
REQ-009 States: IDLE, FETCH, WAIT_DATA, APPLY, OUTPUT.
REQ-010 IDLE: slow accept latches weight/offset -> FETCH; else end_pending -> OUTPUT.
REQ-011 FETCH: fa_addr <= offset, fa_read_en pulsed exactly one cycle -> WAIT_DATA.
REQ-012 WAIT_DATA: hold until fa_valid, latch fa_data -> APPLY; fa_valid in any other state ignored.
REQ-013 APPLY (one cycle): for each lane t with fibre bit 0, corr[t] += stored weight; bit 1 lanes unchanged -> IDLE.
REQ-014 Unlimited correction requests per row; corrections accumulate independently per lane.
REQ-015 row_end sets end_pending; row_end while end_pending or in OUTPUT is ignored; fast/slow beat in same cycle as row_end belongs to current row.
REQ-016 Entering OUTPUT registers result lane t = pseudo - corr[t]; result_valid held high, result_data stable until result_ready.
REQ-017 OUTPUT handshake: pseudo, all corr[t], end_pending cleared -> IDLE; next row starts from zero; result_valid falls next cycle.
REQ-018 Arithmetic without macro: all accumulators and results wrap modulo 2^ACC_WIDTH.
REQ-019 busy = state != IDLE || end_pending.

Reset
REQ-020 rst clears state to IDLE, pseudo, corr[], end_pending, latched weight/offset/data; fast_ready 1, slow_ready 1, fa_read_en 0, fa_addr 0, result_valid 0, result_data 0, busy 0.
REQ-021 Reset mid-read abandons request; a later stray fa_valid has no effect.

Configuration
REQ-022 Macro ACC_SAT_EN defined: pseudo and corr[] saturate at 2^ACC_WIDTH-1; lane result clamps to 0 when corr[t] > pseudo.
REQ-023 ACC_SAT_EN undefined: pure modulo behaviour of REQ-018; no saturation logic synthesised.

Structure
REQ-024 Shared package tppe_pkg holds state enum type and default-width localparams; no per-instance constants in package.
REQ-025 One sub-module corr_lane (one lane's correction accumulator, clear, conditional add, optional saturation), generated TIMESTEPS times.

Verification (TIMESTEPS=8, ACC_WIDTH=12)
REQ-026 fast 3,5,7; slow w=5 off=2, fa_data=8'hF0; row_end -> fa_addr=2 one read pulse; lanes0-3=10, lanes4-7=15.
REQ-027 fast 9; slow w=9 fa_data=8'hFF; row_end -> all lanes 9, no correction.
REQ-028 fast 10,10; slow w=4 data 8'h0F; slow w=2 data 8'hAA; row_end -> lanes0..7 = 18,20,18,20,14,16,14,16.
REQ-029 result_ready low 5 cycles -> result_valid/result_data stable, fast_ready=slow_ready=0; after accept, fast 1 + row_end -> all lanes 1.
REQ-030 fast 2; slow w=5 data 8'h00; row_end -> all lanes 4093 (no macro) / 0 (ACC_SAT_EN).
REQ-031 rst asserted in WAIT_DATA, fa_valid pulsed after release -> all outputs at reset values, state IDLE, busy 0.

Source files
------------

// File: rtl/tppe_pkg.sv
// ============================================================================
// Module   : tppe_pkg
// Purpose  : Shared state encoding and default widths for the corrector.
// Revision : 1.0
// ============================================================================
`default_nettype none

package tppe_pkg;

    localparam int unsigned C_TIMESTEPS_DEF    = 8;
    localparam int unsigned C_WEIGHT_WIDTH_DEF = 8;
    localparam int unsigned C_ACC_WIDTH_DEF    = 12;
    localparam int unsigned C_ADDR_WIDTH_DEF   = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_WAIT_DATA = 3'd2,
        ST_APPLY     = 3'd3,
        ST_OUTPUT    = 3'd4
    } state_e;

endpackage

`default_nettype wire

// File: rtl/corr_lane.sv
// ============================================================================
// Module   : corr_lane
// Purpose  : One lane's correction accumulator (clear / conditional add).
//            Macro ACC_SAT_EN selects saturating instead of wrapping adds.
// Revision : 1.0
// ============================================================================
`default_nettype none

module corr_lane #(
    parameter int ACC_WIDTH    = 12,
    parameter int WEIGHT_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear_i,
    input  logic                    add_i,
    input  logic [WEIGHT_WIDTH-1:0] weight_i,
    output logic [ACC_WIDTH-1:0]    acc_o
);

    logic [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH-1:0] acc_d;

`ifdef ACC_SAT_EN
    logic [ACC_WIDTH:0] sum_w;
    assign sum_w = {1'b0, acc_q} + (ACC_WIDTH+1)'(weight_i);
    assign acc_d = sum_w[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum_w[ACC_WIDTH-1:0];
`else
    assign acc_d = acc_q + ACC_WIDTH'(weight_i);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (clear_i) begin
            acc_q <= '0;
        end else if (add_i) begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

`default_nettype wire

// File: rtl/pseudo_acc_corrector.sv
// ============================================================================
// Module   : pseudo_acc_corrector
// Purpose  : Pseudo accumulator with per-lane fibre-driven corrections.
//            Macro ACC_SAT_EN enables saturating accumulation / clamped results.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pseudo_acc_corrector
    import tppe_pkg::*;
#(
    parameter int TIMESTEPS    = C_TIMESTEPS_DEF,
    parameter int WEIGHT_WIDTH = C_WEIGHT_WIDTH_DEF,
    parameter int ACC_WIDTH    = C_ACC_WIDTH_DEF,
    parameter int ADDR_WIDTH   = C_ADDR_WIDTH_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           fast_valid,
    input  logic [WEIGHT_WIDTH-1:0]        fast_weight,
    output logic                           fast_ready,
    input  logic                           slow_valid,
    input  logic [WEIGHT_WIDTH-1:0]        slow_weight,
    input  logic [ADDR_WIDTH-1:0]          slow_offset,
    output logic                           slow_ready,
    output logic [ADDR_WIDTH-1:0]          fa_addr,
    output logic                           fa_read_en,
    input  logic [TIMESTEPS-1:0]           fa_data,
    input  logic                           fa_valid,
    input  logic                           row_end,
    output logic [TIMESTEPS*ACC_WIDTH-1:0] result_data,
    output logic                           result_valid,
    input  logic                           result_ready,
    output logic                           busy
);

    state_e                         state_q;
    logic [ACC_WIDTH-1:0]           pseudo_q;
    logic [ACC_WIDTH-1:0]           pseudo_d;
    logic                           end_pending_q;
    logic [WEIGHT_WIDTH-1:0]        weight_q;
    logic [ADDR_WIDTH-1:0]          offset_q;
    logic [TIMESTEPS-1:0]           data_q;
    logic [ADDR_WIDTH-1:0]          fa_addr_q;
    logic                           fa_read_en_q;
    logic [TIMESTEPS*ACC_WIDTH-1:0] result_q;
    logic [TIMESTEPS*ACC_WIDTH-1:0] result_d;
    logic                           result_valid_q;

    logic                           fast_fire_w;
    logic                           slow_fire_w;
    logic                           lane_clear_w;
    logic [TIMESTEPS-1:0]           lane_add_w;
    logic [ACC_WIDTH-1:0]           corr_w [TIMESTEPS];

    assign fast_ready   = !end_pending_q && (state_q != ST_OUTPUT);
    assign slow_ready   = (state_q == ST_IDLE) && !end_pending_q;
    assign busy         = (state_q != ST_IDLE) || end_pending_q;
    assign fast_fire_w  = fast_valid && fast_ready;
    assign slow_fire_w  = slow_valid && slow_ready;
    assign lane_clear_w = (state_q == ST_OUTPUT) && result_ready;

    assign fa_addr      = fa_addr_q;
    assign fa_read_en   = fa_read_en_q;
    assign result_data  = result_q;
    assign result_valid = result_valid_q;

`ifdef ACC_SAT_EN
    logic [ACC_WIDTH:0] pseudo_sum_w;
    assign pseudo_sum_w = {1'b0, pseudo_q} + (ACC_WIDTH+1)'(fast_weight);
    assign pseudo_d     = pseudo_sum_w[ACC_WIDTH] ? {ACC_WIDTH{1'b1}}
                                                  : pseudo_sum_w[ACC_WIDTH-1:0];
`else
    assign pseudo_d = pseudo_q + ACC_WIDTH'(fast_weight);
`endif

    // A cleared fibre bit means the lane never saw this weight, so it is
    // subtracted back out of the shared pseudo sum.
    generate
        for (genvar t = 0; t < TIMESTEPS; t++) begin : g_lane
            assign lane_add_w[t] = (state_q == ST_APPLY) && !data_q[t];

            corr_lane #(
                .ACC_WIDTH   (ACC_WIDTH),
                .WEIGHT_WIDTH(WEIGHT_WIDTH)
            ) u_corr_lane (
                .clk     (clk),
                .rst     (rst),
                .clear_i (lane_clear_w),
                .add_i   (lane_add_w[t]),
                .weight_i(weight_q),
                .acc_o   (corr_w[t])
            );
        end
    endgenerate

    always_comb begin
        result_d = '0;
        for (int t = 0; t < TIMESTEPS; t++) begin
`ifdef ACC_SAT_EN
            result_d[t*ACC_WIDTH +: ACC_WIDTH] =
                (corr_w[t] > pseudo_q) ? '0 : (pseudo_q - corr_w[t]);
`else
            result_d[t*ACC_WIDTH +: ACC_WIDTH] = pseudo_q - corr_w[t];
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            pseudo_q       <= '0;
            end_pending_q  <= 1'b0;
            weight_q       <= '0;
            offset_q       <= '0;
            data_q         <= '0;
            fa_addr_q      <= '0;
            fa_read_en_q   <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            fa_read_en_q <= 1'b0;

            if (fast_fire_w) begin
                pseudo_q <= pseudo_d;
            end
            if (row_end && !end_pending_q && (state_q != ST_OUTPUT)) begin
                end_pending_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (slow_fire_w) begin
                        weight_q <= slow_weight;
                        offset_q <= slow_offset;
                        state_q  <= ST_FETCH;
                    end else if (end_pending_q) begin
                        result_q       <= result_d;
                        result_valid_q <= 1'b1;
                        state_q        <= ST_OUTPUT;
                    end
                end
                ST_FETCH: begin
                    fa_addr_q    <= offset_q;
                    fa_read_en_q <= 1'b1;
                    state_q      <= ST_WAIT_DATA;
                end
                ST_WAIT_DATA: begin
                    if (fa_valid) begin
                        data_q  <= fa_data;
                        state_q <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    state_q <= ST_IDLE;
                end
                ST_OUTPUT: begin
                    // Lane accumulators clear on this same handshake.
                    if (result_ready) begin
                        pseudo_q       <= '0;
                        end_pending_q  <= 1'b0;
                        result_valid_q <= 1'b0;
                        state_q        <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pseudo_acc_corrector.sv
// ============================================================================
// Module   : tb_pseudo_acc_corrector
// Purpose  : Scoreboard bench for pseudo_acc_corrector (honours ACC_SAT_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pseudo_acc_corrector;

    localparam int TS = 8;
    localparam int WW = 8;
    localparam int AW = 12;
    localparam int DW = 8;

    logic            clk;
    logic            rst;
    logic            fast_valid;
    logic [WW-1:0]   fast_weight;
    logic            fast_ready;
    logic            slow_valid;
    logic [WW-1:0]   slow_weight;
    logic [DW-1:0]   slow_offset;
    logic            slow_ready;
    logic [DW-1:0]   fa_addr;
    logic            fa_read_en;
    logic [TS-1:0]   fa_data;
    logic            fa_valid;
    logic            row_end;
    logic [TS*AW-1:0] result_data;
    logic            result_valid;
    logic            result_ready;
    logic            busy;

    pseudo_acc_corrector #(
        .TIMESTEPS   (TS),
        .WEIGHT_WIDTH(WW),
        .ACC_WIDTH   (AW),
        .ADDR_WIDTH  (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fast_valid  (fast_valid),
        .fast_weight (fast_weight),
        .fast_ready  (fast_ready),
        .slow_valid  (slow_valid),
        .slow_weight (slow_weight),
        .slow_offset (slow_offset),
        .slow_ready  (slow_ready),
        .fa_addr     (fa_addr),
        .fa_read_en  (fa_read_en),
        .fa_data     (fa_data),
        .fa_valid    (fa_valid),
        .row_end     (row_end),
        .result_data (result_data),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [TS*AW-1:0] exp_q[$];
    logic [TS-1:0]    fa_data_q[$];
    logic [DW-1:0]    fa_addr_q[$];
    bit               fa_auto = 1'b1;
    int               read_cnt = 0;
    int               stray_req = 0;
    int               stray_done = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting on DUT", name);
    endtask

    function automatic logic [TS*AW-1:0] lanes(input int l0, input int l1, input int l2,
                                               input int l3, input int l4, input int l5,
                                               input int l6, input int l7);
        logic [TS*AW-1:0] v;
        v = {AW'(l7), AW'(l6), AW'(l5), AW'(l4), AW'(l3), AW'(l2), AW'(l1), AW'(l0)};
        return v;
    endfunction

    function automatic logic [TS*AW-1:0] all_lanes(input int x);
        return lanes(x, x, x, x, x, x, x, x);
    endfunction

    // Scoreboard monitor: a result is consumed when valid and ready meet.
    initial begin
        logic [TS*AW-1:0] e;
        forever begin
            @(negedge clk);
            if (result_valid && result_ready && !rst) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got 0x%0h expected none", result_data);
                end else begin
                    e = exp_q.pop_front();
                    for (int t = 0; t < TS; t++) begin
                        check($sformatf("lane%0d", t), 128'(result_data[t*AW +: AW]),
                              128'(e[t*AW +: AW]));
                    end
                end
            end
        end
    end

    // Fibre-A memory model: answers each read two cycles later.
    initial begin
        logic [TS-1:0] d;
        fa_valid = 1'b0;
        fa_data  = '0;
        forever begin
            @(negedge clk);
            if (fa_read_en) read_cnt++;
            if (fa_read_en && fa_auto) begin
                if (fa_data_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL fa_request: got read at 0x%0h expected none", fa_addr);
                    d = '0;
                end else begin
                    check("fa_addr", 128'(fa_addr), 128'(fa_addr_q.pop_front()));
                    d = fa_data_q.pop_front();
                end
                repeat (2) @(negedge clk);
                fa_valid = 1'b1;
                fa_data  = d;
                @(negedge clk);
                fa_valid = 1'b0;
            end else if (stray_req != stray_done) begin
                fa_valid = 1'b1;
                fa_data  = '0;
                @(negedge clk);
                fa_valid = 1'b0;
                stray_done++;
            end
        end
    end

    task automatic send_fast(input int w);
        int n;
        @(negedge clk);
        fast_valid  = 1'b1;
        fast_weight = WW'(w);
        n = 0;
        while (!fast_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) timeout_fail("fast_ready");
        @(posedge clk);
        #1 fast_valid = 1'b0;
    endtask

    task automatic send_slow(input int w, input int off, input logic [TS-1:0] d, input bit push);
        int n;
        if (push) begin
            fa_data_q.push_back(d);
            fa_addr_q.push_back(DW'(off));
        end
        @(negedge clk);
        slow_valid  = 1'b1;
        slow_weight = WW'(w);
        slow_offset = DW'(off);
        n = 0;
        while (!slow_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) timeout_fail("slow_ready");
        @(posedge clk);
        #1 slow_valid = 1'b0;
    endtask

    task automatic end_row(input logic [TS*AW-1:0] e);
        exp_q.push_back(e);
        @(negedge clk);
        row_end = 1'b1;
        @(posedge clk);
        #1 row_end = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) timeout_fail("busy_drop");
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_fast_ready"},   128'(fast_ready),   128'(1));
        check({tag, "_slow_ready"},   128'(slow_ready),   128'(1));
        check({tag, "_fa_read_en"},   128'(fa_read_en),   128'(0));
        check({tag, "_fa_addr"},      128'(fa_addr),      128'(0));
        check({tag, "_result_valid"}, 128'(result_valid), 128'(0));
        check({tag, "_result_data"},  128'(result_data),  128'(0));
        check({tag, "_busy"},         128'(busy),         128'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst          = 1'b1;
        fast_valid   = 1'b0;
        fast_weight  = '0;
        slow_valid   = 1'b0;
        slow_weight  = '0;
        slow_offset  = '0;
        row_end      = 1'b0;
        result_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Partial correction on lanes 0-3, single fibre read at offset 2.
        read_cnt = 0;
        send_fast(3);
        send_fast(5);
        send_fast(7);
        send_slow(5, 2, 8'hF0, 1'b1);
        end_row(lanes(10, 10, 10, 10, 15, 15, 15, 15));
        wait_idle();
        check("read_pulses", 128'(read_cnt), 128'(1));

        // All fibre bits set: no lane corrected.
        send_fast(9);
        send_slow(9, 8'h11, 8'hFF, 1'b1);
        end_row(all_lanes(9));
        wait_idle();

        // Two corrections accumulate independently per lane.
        send_fast(10);
        send_fast(10);
        send_slow(4, 3, 8'h0F, 1'b1);
        send_slow(2, 4, 8'hAA, 1'b1);
        end_row(lanes(18, 20, 18, 20, 14, 16, 14, 16));
        wait_idle();

        // Output back-pressure: result must hold, both inputs stalled.
        @(negedge clk);
        result_ready = 1'b0;
        send_fast(3);
        end_row(all_lanes(3));
        n = 0;
        while (!result_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) timeout_fail("result_valid");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid",      128'(result_valid), 128'(1));
            check("hold_data",       128'(result_data),  128'(all_lanes(3)));
            check("hold_fast_ready", 128'(fast_ready),   128'(0));
            check("hold_slow_ready", 128'(slow_ready),   128'(0));
        end
        @(posedge clk);
        #1 result_ready = 1'b1;
        wait_idle();
        check("post_accept_valid", 128'(result_valid), 128'(0));
        send_fast(1);
        end_row(all_lanes(1));
        wait_idle();

        // Correction larger than the pseudo sum.
        send_fast(2);
        send_slow(5, 7, 8'h00, 1'b1);
`ifdef ACC_SAT_EN
        end_row(all_lanes(0));
`else
        end_row(all_lanes(4093));
`endif
        wait_idle();

        // Reset while waiting for fibre data, then a stray fa_valid.
        fa_auto = 1'b0;
        send_slow(3, 9, 8'h00, 1'b0);
        n = 0;
        while (!fa_read_en && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) timeout_fail("fa_read_en");
        @(negedge clk);
        check("wait_busy", 128'(busy), 128'(1));
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        stray_req++;
        repeat (4) @(negedge clk);
        check_reset_outputs("midread");
        fa_auto = 1'b1;
        send_fast(6);
        end_row(all_lanes(6));
        wait_idle();

        check("scoreboard_drain", 128'(exp_q.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
